// File: rtl/addr_shift_reg.sv
// addr_shift_reg: collects the MSB-first I2C word-address bytes into a
// shadow register and hands the completed start address to the address mux
// atomically, together with a one-clock load strobe. It also raises an ACK
// request for the bus controller after each address byte.
module addr_shift_reg #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  sdaIn,
  input  logic                  sclRise,
  input  logic                  startDet,
  input  logic                  stopDet,
  input  logic                  addrPhaseEn,
  output logic [ADDR_WIDTH-1:0] shiftRegOut,
  output logic                  selStartAddr,
  output logic                  ackReq,
  output logic                  byteDone,
  output logic                  busy
);

  // Number of address bytes follows from the width and cannot be overridden.
  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int BYTE_CNT_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(ADDR_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_ONE  = BYTE_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   shadow_q, shadow_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0]   shift_reg_out_q, shift_reg_out_d;
  logic                    sel_start_addr_q, sel_start_addr_d;
  logic                    ack_req_q, ack_req_d;
  logic                    byte_done_q, byte_done_d;
  logic                    busy_q, busy_d;

  logic                    bus_event_s;

  assign bus_event_s = startDet | stopDet;

  // Next-state and next-output computation for the address deserializer.
  always_comb begin
    state_d          = state_q;
    shadow_d         = shadow_q;
    bit_cnt_d        = bit_cnt_q;
    byte_cnt_d       = byte_cnt_q;
    shift_reg_out_d  = shift_reg_out_q;
    sel_start_addr_d = 1'b0;
    byte_done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus_event_s) begin
          state_d = ST_IDLE;
        end else if (addrPhaseEn) begin
          state_d    = ST_SHIFT;
          shadow_d   = '0;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (bus_event_s || !addrPhaseEn) begin
          // Abort: drop the partial address, keep the last good one.
          state_d    = ST_IDLE;
          shadow_d   = '0;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
        end else if (sclRise) begin
          shadow_d = {shadow_q[ADDR_WIDTH-2:0], sdaIn};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b1;
            state_d     = ST_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_ACK: begin
        if (bus_event_s || !addrPhaseEn) begin
          state_d    = ST_IDLE;
          shadow_d   = '0;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
        end else if (sclRise) begin
          // ACK bit clock: SDA belongs to us here, so it is not sampled.
          byte_cnt_d = byte_cnt_q + BYTE_ONE;
          if (byte_cnt_q == LAST_BYTE) begin
            shift_reg_out_d  = shadow_q;
            sel_start_addr_d = 1'b1;
            state_d          = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_ACK;
        end
      end

      ST_DONE: begin
        if (bus_event_s || !addrPhaseEn) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        shadow_d   = '0;
        bit_cnt_d  = 3'd0;
        byte_cnt_d = '0;
      end
    endcase

    // Status outputs are registered views of the state being entered.
    ack_req_d = (state_d == ST_ACK);
    busy_d    = (state_d == ST_SHIFT) || (state_d == ST_ACK);
  end

  // State, counters, shadow and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q          <= ST_IDLE;
      shadow_q         <= '0;
      bit_cnt_q        <= 3'd0;
      byte_cnt_q       <= '0;
      shift_reg_out_q  <= '0;
      sel_start_addr_q <= 1'b0;
      ack_req_q        <= 1'b0;
      byte_done_q      <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      shadow_q         <= shadow_d;
      bit_cnt_q        <= bit_cnt_d;
      byte_cnt_q       <= byte_cnt_d;
      shift_reg_out_q  <= shift_reg_out_d;
      sel_start_addr_q <= sel_start_addr_d;
      ack_req_q        <= ack_req_d;
      byte_done_q      <= byte_done_d;
      busy_q           <= busy_d;
    end
  end

  assign shiftRegOut  = shift_reg_out_q;
  assign selStartAddr = sel_start_addr_q;
  assign ackReq       = ack_req_q;
  assign byteDone     = byte_done_q;
  assign busy         = busy_q;

endmodule
